// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_rd_stream : FWFT FIFO read port to valid/ready stream, 2-entry skid buffer
// Revision       : 1.0
// ----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATASIZE = 8,
  parameter int COUNTW   = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [DATASIZE-1:0] fifo_rdata,
  input  logic                fifo_rempty,
  output logic                fifo_rinc,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic                flush,
  output logic [1:0]          level,
  output logic [COUNTW-1:0]   xfer_count
);

  localparam logic [1:0] c_occ_empty = 2'd0;
  localparam logic [1:0] c_occ_full  = 2'd2;

  logic [DATASIZE-1:0] entry0_q, entry0_d;
  logic [DATASIZE-1:0] entry1_q, entry1_d;
  logic [1:0]          occ_q, occ_d;
  logic [COUNTW-1:0]   cnt_q, cnt_d;
  logic                pop;
  logic                xfer;

  // Pop depends only on occupancy and the FIFO flag, never on m_ready.
  // Gating with rrst_n keeps the pop request low while in reset even if the
  // FIFO has not yet reported empty.
  always_comb begin
    fifo_rinc = rrst_n && !fifo_rempty && (flush || (occ_q != c_occ_full));
    m_valid   = (occ_q != c_occ_empty) && !flush;
    pop       = fifo_rinc;
    xfer      = m_valid && m_ready;
  end

  assign m_data     = entry0_q;
  assign level      = occ_q;
  assign xfer_count = cnt_q;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q + COUNTW'(xfer);
    if (flush) begin
      occ_d = c_occ_empty;
    end else begin
      case ({pop, xfer})
        2'b10: begin
          if (occ_q == c_occ_empty) entry0_d = fifo_rdata;
          else                      entry1_d = fifo_rdata;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          occ_d    = occ_q - 2'd1;
        end
        // Simultaneous pop and transfer only happens at occupancy 1.
        2'b11:   entry0_d = fifo_rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= c_occ_empty;
      cnt_q    <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream : randomized bench with a queue-based FIFO and buffer model
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic [7:0]  fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rinc, fifo_rinc4;
  logic [7:0]  m_data, m_data4;
  logic        m_valid, m_valid4;
  logic        m_ready;
  logic        flush;
  logic [1:0]  level, level4;
  logic [15:0] xfer_count;
  logic [3:0]  xfer_count4;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATASIZE(8), .COUNTW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush(flush), .level(level), .xfer_count(xfer_count)
  );

  fifo_rd_stream #(.DATASIZE(8), .COUNTW(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .flush(flush), .level(level4), .xfer_count(xfer_count4)
  );

  logic [7:0] fifo_q[$];   // words held in the FIFO
  logic [7:0] buf_q[$];    // words held in the stream buffer, oldest first
  logic [7:0] dlog[$];     // words the DUT delivered
  int         dcyc[$];     // cycle index of each delivery
  int         mcount;
  int         cyc;
  int         n_chk, n_fail;
  int         cap15, cap16, cap17;
  bit         push_en;
  logic [7:0] push_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input bit pop_m);
    bit vld;
    vld = (buf_q.size() != 0) && !flush;
    chk("level", 32'(level), 32'(buf_q.size()));
    chk("m_valid", 32'(m_valid), 32'(vld));
    if (vld) chk("m_data", 32'(m_data), 32'(buf_q[0]));
    chk("fifo_rinc", 32'(fifo_rinc), 32'(pop_m));
    chk("xfer_count", 32'(xfer_count), 32'(mcount & 16'hFFFF));
    chk("xfer_count4", 32'(xfer_count4), 32'(mcount & 4'hF));
  endtask

  // One clock cycle: compare at the falling edge, advance the models after
  // the rising edge, then present the new FIFO head.
  task automatic tick();
    bit pop_m, xfer_m;
    logic [7:0] w;
    @(negedge rclk);
    pop_m  = !fifo_rempty && (flush || (buf_q.size() != 2));
    xfer_m = (buf_q.size() != 0) && !flush && m_ready;
    compare(pop_m);
    if (xfer_m) begin
      dlog.push_back(m_data);
      dcyc.push_back(cyc);
    end
    if (mcount == 15) cap15 = int'(xfer_count4);
    if (mcount == 16) cap16 = int'(xfer_count4);
    if (mcount == 17) cap17 = int'(xfer_count4);
    @(posedge rclk);
    #1;
    cyc++;
    w = 8'h00;
    if (pop_m) w = fifo_q.pop_front();
    if (flush) buf_q.delete();
    else begin
      if (xfer_m) void'(buf_q.pop_front());
      if (pop_m) buf_q.push_back(w);
    end
    if (xfer_m) mcount++;
    if (push_en) fifo_q.push_back(push_word);
    push_en = 1'b0;
    fifo_rempty = (fifo_q.size() == 0);
    if (!fifo_rempty) fifo_rdata = fifo_q[0];
  endtask

  task automatic push_tick(input logic [7:0] w);
    push_en   = 1'b1;
    push_word = w;
    tick();
  endtask

  initial begin
    int base;
    n_chk = 0; n_fail = 0; mcount = 0; cyc = 0;
    cap15 = -1; cap16 = -1; cap17 = -1;
    rrst_n = 1'b0; fifo_rdata = 8'h00; fifo_rempty = 1'b1;
    m_ready = 1'b0; flush = 1'b0; push_en = 1'b0; push_word = 8'h00;

    // Reset values
    #2;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_count", 32'(xfer_count), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_rinc", 32'(fifo_rinc), 0);
    @(posedge rclk); #1;
    rrst_n = 1'b1;

    // Three words, downstream always ready
    m_ready = 1'b1;
    push_tick(8'h11); push_tick(8'h22); push_tick(8'h33);
    repeat (4) tick();
    chk("t1_n", 32'(dlog.size()), 3);
    chk("t1_w0", 32'(dlog[0]), 32'h11);
    chk("t1_w1", 32'(dlog[1]), 32'h22);
    chk("t1_w2", 32'(dlog[2]), 32'h33);
    chk("t1_back2back", 32'(dcyc[2] - dcyc[0]), 2);
    chk("t1_count", 32'(xfer_count), 3);
    chk("t1_level", 32'(level), 0);

    // Backpressure: only two words leave the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_tick(8'hA0 + 8'(i));
    repeat (3) tick();
    chk("t2_level", 32'(level), 2);
    chk("t2_rinc", 32'(fifo_rinc), 0);
    chk("t2_hold", 32'(m_data), 32'hA0);
    chk("t2_fifo_left", 32'(fifo_q.size()), 3);
    m_ready = 1'b1;
    repeat (8) tick();
    chk("t2_n", 32'(dlog.size()), 8);
    for (int i = 0; i < 5; i++) chk("t2_word", 32'(dlog[3 + i]), 32'hA0 + 32'(i));
    chk("t2_nogap", 32'(dcyc[7] - dcyc[3]), 4);
    chk("t2_count", 32'(xfer_count), 8);
    chk("t2_count4", 32'(xfer_count4), 8);

    // 256 words with random push and ready pattern
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 5000 && dlog.size() < 264; c++) begin
        m_ready = 1'($urandom_range(0, 1));
        if (sent < 256 && $urandom_range(0, 2) != 0) begin
          push_en = 1'b1; push_word = 8'(sent); sent++;
        end
        tick();
      end
    end
    chk("t3_done", 32'(dlog.size()), 264);
    for (int i = 0; i < 256; i++)
      if (8 + i < dlog.size()) chk("t3_order", 32'(dlog[8 + i]), 32'(i));
    chk("t3_count", 32'(xfer_count), 264);
    chk("t3_wrap15", 32'(cap15), 15);
    chk("t3_wrap0", 32'(cap16), 0);
    chk("t3_wrap1", 32'(cap17), 1);

    // Flush with two buffered words and four more queued
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_tick(8'(i));
    repeat (2) tick();
    chk("t4_level", 32'(level), 2);
    chk("t4_head", 32'(m_data), 32'h01);
    flush = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 20 && !fifo_rempty; c++) begin
      tick();
      chk("t4_valid_low", 32'(m_valid), 0);
    end
    chk("t4_drained", 32'(fifo_rempty), 1);
    chk("t4_level0", 32'(level), 0);
    chk("t4_count_kept", 32'(xfer_count), 264);
    base = dlog.size();
    flush = 1'b0;
    push_tick(8'h77);
    repeat (3) tick();
    chk("t4_next_n", 32'(dlog.size()), 32'(base + 1));
    if (dlog.size() > base) chk("t4_next_word", 32'(dlog[base]), 32'h77);

    // Asynchronous reset with a full buffer
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_tick(8'h51 + 8'(i));
    repeat (2) tick();
    chk("t5_level", 32'(level), 2);
    chk("t5_rinc_pre", 32'(fifo_rinc), 0);
    #1;
    rrst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_rinc", 32'(fifo_rinc), 0);
    chk("t5_level0", 32'(level), 0);
    chk("t5_count", 32'(xfer_count), 0);
    fifo_q.delete(); buf_q.delete(); mcount = 0;
    fifo_rempty = 1'b1;
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    m_ready = 1'b1;
    base = dlog.size();
    push_tick(8'h99);
    repeat (3) tick();
    chk("t5_after_n", 32'(dlog.size()), 32'(base + 1));
    if (dlog.size() > base) chk("t5_after_word", 32'(dlog[base]), 32'h99);
    chk("t5_after_count", 32'(xfer_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
